regfile_write_arbiter: RTL and testbench

- Shares the single 16-entry, 8-bit register-file write port between 4 requesters: ALU writeback, load unit, PC/link save and the debug port.
- Round-robin arbitration grants at most one write per cycle.
- The winning 4-bit register address is converted to a one-hot write-enable vector through the 4-to-16 decoder.
- Write enable, write data and per-requester acknowledge are registered; the block sits between the execute/memory stages and the register file.

---
 rtl/regfile_write_arbiter_pkg.sv | 15 +
 rtl/regfile_write_arbiter_decoder4to16.sv | 15 +
 rtl/regfile_write_arbiter.sv | 73 +++++++
 tb/tb_regfile_write_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: sizes and requester indices.
package regfile_write_arbiter_pkg;

    localparam int NREQ = 4;
    localparam int PW   = 2;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int NREG = 1 << AW;

    localparam logic [PW-1:0] REQ_ALU  = 2'd0;
    localparam logic [PW-1:0] REQ_LOAD = 2'd1;
    localparam logic [PW-1:0] REQ_LINK = 2'd2;
    localparam logic [PW-1:0] REQ_DBG  = 2'd3;

endpackage

// File: rtl/regfile_write_arbiter_decoder4to16.sv
// 4-to-16 one-hot decoder used to turn the winning address into a write-enable vector.
import regfile_write_arbiter_pkg::*;

module decoder4to16 (
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] dec
);

    always_comb begin
        // NOTE: default the whole output before the indexed write so no bit can infer a latch.
        dec       = '0;
        dec[addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among four requesters,
// with registered one-hot write enable, write data and per-requester acknowledge.
import regfile_write_arbiter_pkg::*;

module regfile_write_arbiter (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ*AW-1:0]  ADDR,
    input  logic [NREQ*DW-1:0]  WDIN,
    input  logic                STALL,
    output logic [NREG-1:0]     WE,
    output logic [DW-1:0]       WDATA,
    output logic [NREQ-1:0]     ACK,
    output logic                BUSY
);

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] elig;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic [NREG-1:0] dec_we;

    // A requester acked this cycle still has REQ high; masking it avoids a double grant.
    assign elig = REQ & ~ACK;
    assign BUSY = |elig;

    // Walk from the farthest offset back to ptr so the closest eligible index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + PW'(k);
            if (elig[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        if (STALL)
            win_valid = 1'b0;
    end

    assign win_addr = ADDR[int'(win_idx)*AW +: AW];
    assign win_data = WDIN[int'(win_idx)*DW +: DW];

    decoder4to16 u_dec (
        .addr (win_addr),
        .dec  (dec_we)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            WE    <= '0;
            WDATA <= '0;
            ACK   <= '0;
            ptr   <= '0;
        end else if (win_valid) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            WE    <= dec_we;
            WDATA <= win_data;
            ACK   <= NREQ'(1) << win_idx;
            ptr   <= win_idx + PW'(1);
        end else begin
            WE    <= '0;
            ACK   <= '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter with hand-computed expectations.
`timescale 1ns/1ps
import regfile_write_arbiter_pkg::*;

module tb_regfile_write_arbiter;

    logic                CLK = 1'b0;
    logic                RSTn;
    logic [NREQ-1:0]     REQ;
    logic [NREQ*AW-1:0]  ADDR;
    logic [NREQ*DW-1:0]  WDIN;
    logic                STALL;
    logic [NREG-1:0]     WE;
    logic [DW-1:0]       WDATA;
    logic [NREQ-1:0]     ACK;
    logic                BUSY;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .REQ   (REQ),
        .ADDR  (ADDR),
        .WDIN  (WDIN),
        .STALL (STALL),
        .WE    (WE),
        .WDATA (WDATA),
        .ACK   (ACK),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] we, input logic [7:0] wd,
                             input logic [3:0] ack);
        check({tag, ".we"},    32'(WE),    32'(we));
        check({tag, ".wdata"}, 32'(WDATA), 32'(wd));
        check({tag, ".ack"},   32'(ACK),   32'(ack));
    endtask

    initial begin
        logic [3:0]  c_ack [4];
        logic [15:0] c_we  [4];
        logic [7:0]  c_wd  [4];

        RSTn  = 1'b0;
        REQ   = '0;
        ADDR  = '0;
        WDIN  = '0;
        STALL = 1'b0;

        // Reset and idle
        tick();
        tick();
        check_out("reset", 16'h0000, 8'h00, 4'b0000);
        RSTn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("idle", 16'h0000, 8'h00, 4'b0000);
            check("idle.busy", 32'(BUSY), 32'd0);
        end

        // Single write from requester 0
        REQ[REQ_ALU]  = 1'b1;
        ADDR[3:0]     = 4'h5;
        WDIN[7:0]     = 8'hA3;
        #1;
        check("single.busy_pre", 32'(BUSY), 32'd1);
        tick();
        check_out("single", 16'h0020, 8'hA3, 4'b0001);
        check("single.busy_masked", 32'(BUSY), 32'd0);
        REQ = '0;
        tick();
        check_out("single.after", 16'h0000, 8'hA3, 4'b0000);

        // Debug port writes address 15; pointer moves from 1 past 3 back to 0
        REQ[REQ_DBG]  = 1'b1;
        ADDR[15:12]   = 4'hF;
        WDIN[31:24]   = 8'hD3;
        tick();
        check_out("dbg", 16'h8000, 8'hD3, 4'b1000);
        REQ = '0;
        tick();
        check_out("dbg.after", 16'h0000, 8'hD3, 4'b0000);

        // Full contention from ptr=0; each requester drops REQ after its ACK
        ADDR = {4'hF, 4'h7, 4'h2, 4'h1};
        WDIN = {8'hF3, 8'h72, 8'h21, 8'h10};
        c_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        c_we  = '{16'h0002, 16'h0004, 16'h0080, 16'h8000};
        c_wd  = '{8'h10, 8'h21, 8'h72, 8'hF3};
        REQ = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("contend%0d", i), c_we[i], c_wd[i], c_ack[i]);
            REQ = REQ & ~c_ack[i];
        end
        tick();
        check_out("contend.after", 16'h0000, 8'hF3, 4'b0000);

        // STALL holds off a request from the link requester
        REQ   = 4'b0100;
        ADDR  = {4'h0, 4'h3, 4'h0, 4'h0};
        WDIN  = {8'h00, 8'h5C, 8'h00, 8'h00};
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("stall%0d", i), 16'h0000, 8'hF3, 4'b0000);
            check("stall.busy", 32'(BUSY), 32'd1);
        end
        STALL = 1'b0;
        tick();
        check_out("stall.release", 16'h0008, 8'h5C, 4'b0100);
        REQ = '0;
        tick();
        check_out("stall.after", 16'h0000, 8'h5C, 4'b0000);

        // Held request from the load unit is granted every other cycle
        REQ  = 4'b0010;
        ADDR = {4'h0, 4'h0, 4'hA, 4'h0};
        WDIN = {8'h00, 8'h00, 8'hB7, 8'h00};
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i % 2 == 0)
                check_out($sformatf("held%0d", i), 16'h0400, 8'hB7, 4'b0010);
            else
                check_out($sformatf("held%0d", i), 16'h0000, 8'hB7, 4'b0000);
        end
        REQ = '0;
        tick();
        check_out("held.after", 16'h0000, 8'hB7, 4'b0000);

        // Reset in the cycle WE is asserted; ptr=2 favours requester 3 first
        REQ  = 4'b1001;
        ADDR = {4'h9, 4'h0, 4'h0, 4'h4};
        WDIN = {8'h99, 8'h00, 8'h00, 8'h44};
        tick();
        check_out("midrst.grant", 16'h0200, 8'h99, 4'b1000);
        #1;
        RSTn = 1'b0;
        #1;
        check_out("midrst.async", 16'h0000, 8'h00, 4'b0000);
        tick();
        check_out("midrst.held", 16'h0000, 8'h00, 4'b0000);
        RSTn = 1'b1;
        tick();
        check_out("midrst.regrant0", 16'h0010, 8'h44, 4'b0001);
        REQ = 4'b1000;
        tick();
        check_out("midrst.regrant3", 16'h0200, 8'h99, 4'b1000);
        REQ = '0;
        tick();
        check_out("midrst.after", 16'h0000, 8'h99, 4'b0000);
        check("final.busy", 32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
